// File: rtl/ecc_seq_ctrl.sv
// Session controller for the ECC point-multiplication core: serial basepoint
// capture, word-wise key load, core launch with watchdog, done/error report.
module ecc_seq_ctrl #(
  parameter int KEY_W       = 176,
  parameter int WORD_W      = 16,
  parameter int BP_W        = 163,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_time_up,
  input  logic              i_auth_shift,
  input  logic              i_auth_bit,
  input  logic              i_auth_ok,
  input  logic [1:0]        i_auth_step,
  input  logic              i_key_valid,
  input  logic [WORD_W-1:0] i_key_word,
  input  logic              i_done_core,
  output logic              o_key_req,
  output logic              o_start,
  output logic              o_en,
  output logic [KEY_W-1:0]  o_key,
  output logic [BP_W-1:0]   o_basepoint,
  output logic              o_done,
  output logic [1:0]        o_err,
  output logic              o_busy
);

  localparam int NWORDS = KEY_W / WORD_W;
  localparam int BCNT_W = $clog2(BP_W + 2);
  localparam int WCNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int WD_W   = $clog2(TIMEOUT_CYC);

  localparam logic [BCNT_W-1:0] BCNT_SAT  = BCNT_W'(BP_W + 1);
  localparam logic [BCNT_W-1:0] BCNT_FULL = BCNT_W'(BP_W);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(NWORDS - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ_AUTH, S_READ_KEY, S_START, S_COMPUTE, S_FINISH
  } state_t;

  state_t              r_state;
  logic [BCNT_W-1:0]   r_bcnt;
  logic [WCNT_W-1:0]   r_wcnt;
  logic [WD_W-1:0]     r_wdog;
  logic [1:0]          r_step;
  logic                r_bp_valid;
  logic [KEY_W-1:0]    r_key;
  logic [BP_W-1:0]     r_bp;
  logic [1:0]          r_err;

  logic                w_bp_shift;
  logic [BCNT_W-1:0]   w_bcnt_inc;
  logic [BCNT_W-1:0]   w_bcnt_now;

  // A shift arriving with i_auth_ok is counted before the length check.
  assign w_bp_shift = i_auth_shift && (i_auth_step == 2'd1) &&
                      ((r_state == S_IDLE) || (r_state == S_READ_AUTH));
  assign w_bcnt_inc = (r_bcnt == BCNT_SAT) ? r_bcnt : r_bcnt + 1'b1;
  assign w_bcnt_now = w_bp_shift ? w_bcnt_inc : r_bcnt;

  assign o_key_req   = (r_state == S_READ_KEY);
  assign o_start     = (r_state == S_START);
  assign o_en        = (r_state == S_START) || (r_state == S_COMPUTE);
  assign o_done      = (r_state == S_FINISH);
  assign o_busy      = (r_state != S_IDLE);
  assign o_key       = r_key;
  assign o_basepoint = r_bp;
  assign o_err       = r_err;

  // Session FSM; i_time_up aborts everything but keeps the stored basepoint.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bcnt     <= '0;
      r_wcnt     <= '0;
      r_wdog     <= '0;
      r_step     <= 2'd0;
      r_bp_valid <= 1'b0;
      r_key      <= '0;
      r_bp       <= '0;
      r_err      <= 2'd0;
    end else if (i_time_up) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
      r_wcnt  <= '0;
      r_wdog  <= '0;
      r_key   <= '0;
    end else begin
      if (w_bp_shift) begin
        r_bp <= {r_bp[BP_W-2:0], i_auth_bit};
      end
      case (r_state)
        S_IDLE: begin
          if (i_auth_shift) begin
            r_state <= S_READ_AUTH;
            r_err   <= 2'd0;
            r_bcnt  <= w_bp_shift ? BCNT_W'(1) : BCNT_W'(0);
          end
        end
        S_READ_AUTH: begin
          r_bcnt <= w_bcnt_now;
          if (i_auth_ok) begin
            r_step <= i_auth_step;
            r_wcnt <= '0;
            if (i_auth_step == 2'd1) begin
              if (w_bcnt_now != BCNT_FULL) begin
                r_err   <= 2'd1;
                r_state <= S_FINISH;
              end else begin
                r_bp_valid <= 1'b1;
                r_state    <= S_READ_KEY;
              end
            end else if ((i_auth_step == 2'd3) ||
                         ((i_auth_step == 2'd2) && !r_bp_valid)) begin
              r_err   <= 2'd2;
              r_state <= S_FINISH;
            end else begin
              r_state <= S_READ_KEY;
            end
          end
        end
        S_READ_KEY: begin
          if (i_key_valid) begin
            r_key <= {r_key[KEY_W-WORD_W-1:0], i_key_word};
            if (r_wcnt == WCNT_LAST) begin
              r_state <= (r_step == 2'd0) ? S_FINISH : S_START;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
            end
          end
        end
        S_START: begin
          r_wdog  <= '0;
          r_state <= S_COMPUTE;
        end
        S_COMPUTE: begin
          if (i_done_core) begin
            r_err   <= 2'd0;
            r_state <= S_FINISH;
          end else if (r_wdog == WD_LAST) begin
            r_err   <= 2'd3;
            r_state <= S_FINISH;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_seq_ctrl.sv
// Directed bench for ecc_seq_ctrl: stimulus tasks maintain a session-level
// model of the expected outputs, and one negedge process compares every cycle.
module tb_ecc_seq_ctrl;

  localparam int KW = 176;
  localparam int WW = 16;
  localparam int BW = 163;
  localparam int TO = 128;
  localparam int NW = KW / WW;
  localparam logic [167:0] PAT168  = {21{8'h5A}};
  localparam logic [KW-1:0] KEY_SEQ =
    176'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A_000B;

  logic          clk, rst, i_time_up, i_auth_shift, i_auth_bit, i_auth_ok;
  logic [1:0]    i_auth_step;
  logic          i_key_valid, i_done_core;
  logic [WW-1:0] i_key_word;
  logic          o_key_req, o_start, o_en, o_done, o_busy;
  logic [KW-1:0] o_key;
  logic [BW-1:0] o_basepoint;
  logic [1:0]    o_err;

  ecc_seq_ctrl #(.KEY_W(KW), .WORD_W(WW), .BP_W(BW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .i_time_up(i_time_up), .i_auth_shift(i_auth_shift),
    .i_auth_bit(i_auth_bit), .i_auth_ok(i_auth_ok), .i_auth_step(i_auth_step),
    .i_key_valid(i_key_valid), .i_key_word(i_key_word), .i_done_core(i_done_core),
    .o_key_req(o_key_req), .o_start(o_start), .o_en(o_en), .o_key(o_key),
    .o_basepoint(o_basepoint), .o_done(o_done), .o_err(o_err), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_en = 0;
  int n_start = 0;
  int n_done = 0;

  // Expected architectural state and per-cycle control outputs.
  logic [BW-1:0] m_bp;
  logic [KW-1:0] m_key;
  logic [1:0]    m_err;
  bit            m_bpv;
  logic          e_busy, e_req, e_start, e_en, e_done;

  // Pending hand-computed expectation, handed to the compare process.
  int            lit_seq = 0;
  int            lit_ack = 0;
  string         lit_name;
  logic [255:0]  lit_act, lit_exp;

  task automatic cmp(input string nm, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (lit_seq != lit_ack) begin
      lit_ack = lit_seq;
      cmp(lit_name, lit_act, lit_exp);
    end
    if (!rst) begin
      cmp("busy",    256'(o_busy),      256'(e_busy));
      cmp("key_req", 256'(o_key_req),   256'(e_req));
      cmp("start",   256'(o_start),     256'(e_start));
      cmp("en",      256'(o_en),        256'(e_en));
      cmp("done",    256'(o_done),      256'(e_done));
      cmp("err",     256'(o_err),       256'(m_err));
      cmp("key",     256'(o_key),       256'(m_key));
      cmp("bp",      256'(o_basepoint), 256'(m_bp));
      n_en    += int'(o_en);
      n_start += int'(o_start);
      n_done  += int'(o_done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic b, input logic r, input logic s,
                         input logic en, input logic d);
    e_busy = b; e_req = r; e_start = s; e_en = en; e_done = d;
  endtask

  task automatic pin(input string nm, input logic [255:0] a, input logic [255:0] e);
    lit_name = nm;
    lit_act  = a;
    lit_exp  = e;
    lit_seq++;
    tick();
  endtask

  task automatic finish_seq(input logic [1:0] err);
    m_err = err;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // nbits strobes of the 0x5A stream; merge puts i_auth_ok on the last strobe.
  task automatic auth(input int step, input int nbits, input bit merge);
    int  cnt;
    logic b;
    cnt = 0;
    for (int i = 0; i < nbits; i++) begin
      b            = PAT168[167-i];
      i_auth_shift = 1'b1;
      i_auth_bit   = b;
      i_auth_step  = 2'(step);
      i_auth_ok    = (merge && i == nbits - 1);
      tick();
      if (i == 0) m_err = 2'd0;
      if (step == 1) begin
        m_bp = {m_bp[BW-2:0], b};
        cnt++;
      end
      set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    i_auth_shift = 1'b0;
    if (!merge) begin
      i_auth_ok = 1'b1;
      tick();
    end
    i_auth_ok = 1'b0;
    if (step == 1 && cnt != BW) begin
      finish_seq(2'd1);
    end else if (step == 1) begin
      m_bpv = 1'b1;
      set_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end else if ((step == 2 && !m_bpv) || step == 3) begin
      finish_seq(2'd2);
    end else begin
      set_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // n words base, base+1, ...; an idle gap before the fourth word.
  task automatic load(input int n, input logic [WW-1:0] base, input int step);
    logic [WW-1:0] w;
    for (int i = 0; i < n; i++) begin
      if (i == 3) tick();
      w           = base + WW'(i);
      i_key_valid = 1'b1;
      i_key_word  = w;
      tick();
      i_key_valid = 1'b0;
      m_key = {m_key[KW-WW-1:0], w};
      if (i == NW - 1) begin
        if (step == 0) finish_seq(2'd0);
        else           set_exp(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      end
    end
  endtask

  // Core reports done in COMPUTE cycle done_at (negative: never).
  task automatic compute(input int done_at);
    tick();
    set_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < TO; c++) begin
      i_done_core = (c == done_at);
      tick();
      i_done_core = 1'b0;
      if (c == done_at) begin
        finish_seq(2'd0);
        break;
      end else if (c == TO - 1) begin
        finish_seq(2'd3);
      end
    end
  endtask

  task automatic time_up();
    i_time_up = 1'b1;
    tick();
    i_time_up = 1'b0;
    m_key = '0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  int s0, d0, e0;

  initial begin
    rst = 1'b1; i_time_up = 1'b0; i_auth_shift = 1'b0; i_auth_bit = 1'b0;
    i_auth_ok = 1'b0; i_auth_step = 2'd0; i_key_valid = 1'b0;
    i_key_word = '0; i_done_core = 1'b0;
    m_bp = '0; m_key = '0; m_err = 2'd0; m_bpv = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    pin("rst_ctl", 256'({o_busy, o_key_req, o_start, o_en, o_done, o_err}), 256'd0);
    pin("rst_key", 256'(o_key), 256'd0);
    pin("rst_bp",  256'(o_basepoint), 256'd0);
    rst = 1'b0;
    tick();

    auth(1, BW - 1, 1'b0);
    pin("err_len", 256'(o_err), 256'd1);
    auth(2, 1, 1'b0);
    pin("err_nobp", 256'(o_err), 256'd2);
    auth(3, 1, 1'b0);
    pin("err_illegal", 256'(o_err), 256'd2);

    s0 = n_start;
    auth(1, BW, 1'b0);
    load(NW, 16'h0001, 1);
    compute(100);
    pin("bp_pattern", 256'(o_basepoint), 256'(PAT168[167:5]));
    pin("key_seq", 256'(o_key), 256'(KEY_SEQ));
    pin("err_ok", 256'(o_err), 256'd0);
    pin("start_pulses", 256'(n_start - s0), 256'd1);

    s0 = n_start; d0 = n_done;
    auth(0, 1, 1'b0);
    load(NW, 16'hA000, 0);
    pin("keyonly_start", 256'(n_start - s0), 256'd0);
    pin("keyonly_done", 256'(n_done - d0), 256'd1);

    auth(1, BW, 1'b1);
    load(NW, 16'h0100, 1);
    compute(10);
    auth(2, 1, 1'b0);
    load(NW, 16'h0200, 2);
    compute(5);
    pin("bp_reused", 256'(o_basepoint), 256'(PAT168[167:5]));

    e0 = n_en;
    auth(2, 1, 1'b0);
    load(NW, 16'h0300, 2);
    compute(-1);
    pin("en_cycles", 256'(n_en - e0), 256'(TO + 1));
    pin("err_timeout", 256'(o_err), 256'd3);
    auth(2, 1, 1'b0);
    load(NW, 16'h0310, 2);
    compute(TO - 1);
    pin("err_race", 256'(o_err), 256'd0);

    d0 = n_done;
    auth(2, 1, 1'b0);
    load(5, 16'h0400, 2);
    time_up();
    pin("tu_key", 256'(o_key), 256'd0);
    pin("tu_busy", 256'(o_busy), 256'd0);
    pin("tu_done", 256'(n_done - d0), 256'd0);
    pin("tu_bp", 256'(o_basepoint), 256'(PAT168[167:5]));
    auth(0, 1, 1'b0);
    load(NW, 16'h0001, 0);
    pin("key_after_tu", 256'(o_key), 256'(KEY_SEQ));

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
